// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and CPU-port state type
// used by the framebuffer arbiter and the address mapper.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int H_TOTAL    = 800;
    localparam int V_TOTAL    = 525;

    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int SCALE_LOG2 = 2;

    typedef enum logic {
        IDLE,
        ACK
    } cpu_state_t;

endpackage

// File: rtl/vga_fb_addr.sv
// Maps a screen pixel coordinate to the framebuffer entry that covers it
// (each entry is a 2^SCALE_LOG2 square of screen pixels).
module vga_fb_addr #(
    parameter int FB_W       = vga_pkg::FB_W,
    parameter int SCALE_LOG2 = vga_pkg::SCALE_LOG2,
    parameter int ADDR_W     = 15
) (
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [ADDR_W-1:0] scan_addr
);

    // Full 32-bit product, truncated to the RAM address width at the end.
    assign scan_addr = ADDR_W'((32'(pixel_y) >> SCALE_LOG2) * 32'(FB_W)
                             + (32'(pixel_x) >> SCALE_LOG2));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port synchronous framebuffer RAM between VGA scan-out
// (absolute priority) and a CPU req/ack port that uses every other cycle.
module vga_fb_arbiter #(
    parameter int FB_W       = vga_pkg::FB_W,
    parameter int FB_H       = vga_pkg::FB_H,
    parameter int SCALE_LOG2 = vga_pkg::SCALE_LOG2,
    parameter int COLOR_W    = 8,
    parameter int ADDR_W     = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               video_on_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [COLOR_W-1:0] cpu_wdata,
    output logic               cpu_ack,
    output logic [COLOR_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on
);

    localparam int FB_SIZE = FB_W * FB_H;

    vga_pkg::cpu_state_t state, state_next;

    logic [ADDR_W-1:0]  scan_addr;
    logic               scan_slot;
    logic               grant;
    logic               addr_ok;
    logic               read_ok;
    logic               scan_d1;
    logic [COLOR_W-1:0] color_hold;
    logic [1:0]         von_pipe;
    logic [1:0]         hs_pipe;
    logic [1:0]         vs_pipe;

    vga_fb_addr #(
        .FB_W       (FB_W),
        .SCALE_LOG2 (SCALE_LOG2),
        .ADDR_W     (ADDR_W)
    ) u_addr (
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .scan_addr (scan_addr)
    );

    assign scan_slot = video_on_in && (pixel_x[SCALE_LOG2-1:0] == '0);
    assign addr_ok   = 32'(cpu_addr) < 32'(FB_SIZE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= vga_pkg::IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remembers whether the granted access should return RAM data at ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_ok <= 1'b0;
        end else if (grant) begin
            read_ok <= !cpu_we && addr_ok;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        cpu_ack    = 1'b0;
        cpu_rdata  = '0;
        mem_addr   = scan_addr;
        mem_we     = 1'b0;
        mem_wdata  = cpu_wdata;
        case (state)
            vga_pkg::IDLE: begin
                if (cpu_req && !scan_slot) begin
                    grant      = 1'b1;
                    mem_addr   = cpu_addr;
                    mem_we     = cpu_we && addr_ok;
                    state_next = vga_pkg::ACK;
                end
            end
            vga_pkg::ACK: begin
                cpu_ack    = 1'b1;
                if (read_ok) begin
                    cpu_rdata = mem_rdata;
                end
                state_next = vga_pkg::IDLE;
            end
            default: state_next = vga_pkg::IDLE;
        endcase
    end

    // Two-stage alignment: address in stage 0, RAM data lands in color_hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_d1    <= 1'b0;
            color_hold <= '0;
            von_pipe   <= '0;
            hs_pipe    <= '1;
            vs_pipe    <= '1;
        end else begin
            scan_d1  <= scan_slot;
            if (scan_d1) begin
                color_hold <= mem_rdata;
            end
            von_pipe <= {von_pipe[0], video_on_in};
            hs_pipe  <= {hs_pipe[0], hsync_in};
            vs_pipe  <= {vs_pipe[0], vsync_in};
        end
    end

    assign rgb      = von_pipe[1] ? color_hold : '0;
    assign video_on = von_pipe[1];
    assign hsync    = hs_pipe[1];
    assign vsync    = vs_pipe[1];

endmodule
